uart_avalon_bridge: RTL

- Serial-to-Avalon-MM initiator: receives command frames on an 8N1 UART line and issues single-word Avalon MM reads/writes as bus master.
- Returns read data or ACK/NAK bytes on its own UART transmitter.
- Sits between an external host serial port and the on-chip Avalon fabric; it is the bus-initiator counterpart of our UART-attached Avalon slave peripherals.

---
 rtl/uart_avalon_bridge.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_avalon_bridge.sv
// UART (8N1) command frames -> single-word Avalon-MM read/write; replies with ACK/NAK or read data.
// Latency: bus request 1 cycle after last frame byte; no backpressure on rxd, bytes arriving while busy are dropped with status_err.
module uart_avalon_bridge #(
    parameter int N_BIT = 8,
    parameter int AAW   = 8,
    parameter int ADW   = 32,
    parameter int ABW   = ADW / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rxd,
    output logic             uart_txd,
    output logic [AAW-1:0]   avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [ADW-1:0]   avm_writedata,
    output logic [ABW-1:0]   avm_byteenable,
    input  logic [ADW-1:0]   avm_readdata,
    input  logic             avm_waitrequest,
    output logic             status_err
);

    localparam int             BCW     = $clog2(ABW) + 1;
    localparam logic [7:0]     HALF_M1 = 8'(N_BIT / 2 - 1);
    localparam logic [7:0]     BIT_M1  = 8'(N_BIT - 1);
    localparam logic [BCW-1:0] LAST_B  = BCW'(ABW - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS_WR, S_BUS_RD, S_RESP} state_t;

    // ---------------- receiver ----------------
    logic      r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t r_rx_st;
    logic [7:0] r_rx_cnt;
    logic [2:0] r_rx_bit;
    logic [7:0] r_rx_byte;
    logic       r_rx_vld, r_rx_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_byte <= '0;
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_st  <= RX_START;
                        r_rx_cnt <= HALF_M1;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != 8'd0) begin
                        r_rx_cnt <= r_rx_cnt - 8'd1;
                    end else if (r_rx_s2) begin
                        r_rx_st <= RX_IDLE;  // start bit gone by mid-bit: glitch
                    end else begin
                        r_rx_st  <= RX_DATA;
                        r_rx_cnt <= BIT_M1;
                        r_rx_bit <= '0;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != 8'd0) begin
                        r_rx_cnt <= r_rx_cnt - 8'd1;
                    end else begin
                        r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
                        r_rx_cnt  <= BIT_M1;
                        if (r_rx_bit == 3'd7) r_rx_st  <= RX_STOP;
                        else                  r_rx_bit <= r_rx_bit + 3'd1;
                    end
                end
                default: begin
                    if (r_rx_cnt != 8'd0) begin
                        r_rx_cnt <= r_rx_cnt - 8'd1;
                    end else begin
                        r_rx_vld  <= r_rx_s2;
                        r_rx_ferr <= !r_rx_s2;
                        r_rx_st   <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic       r_txd, r_tx_busy;
    logic [8:0] r_tx_shift;
    logic [3:0] r_tx_idx;
    logic [7:0] r_tx_cnt;
    logic       w_tx_done, w_tx_go;

    state_t          r_state;
    logic [ADW-1:0]  r_resp_data;
    logic [BCW-1:0]  r_resp_left;

    assign w_tx_done = r_tx_busy && (r_tx_idx == 4'd9) && (r_tx_cnt == 8'd0);
    // Reload on the last cycle of a stop bit so consecutive bytes have no idle gap.
    assign w_tx_go   = (r_state == S_RESP) && (r_resp_left != '0) && (!r_tx_busy || w_tx_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '1;
            r_tx_idx   <= '0;
            r_tx_cnt   <= '0;
        end else if (w_tx_go) begin
            r_txd      <= 1'b0;
            r_tx_shift <= {1'b1, r_resp_data[7:0]};
            r_tx_idx   <= '0;
            r_tx_cnt   <= BIT_M1;
            r_tx_busy  <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt != 8'd0) begin
                r_tx_cnt <= r_tx_cnt - 8'd1;
            end else if (r_tx_idx == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_txd     <= 1'b1;
            end else begin
                r_txd      <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_idx   <= r_tx_idx + 4'd1;
                r_tx_cnt   <= BIT_M1;
            end
        end
    end

    // ---------------- command FSM / Avalon master ----------------
    logic            r_is_wr;
    logic [BCW-1:0]  r_bcnt;
    logic            r_err, r_rd, r_wr;
    logic [AAW-1:0]  r_addr;
    logic [ADW-1:0]  r_wdata;
    logic [ABW-1:0]  r_be;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_is_wr     <= 1'b0;
            r_bcnt      <= '0;
            r_resp_data <= '0;
            r_resp_left <= '0;
            r_err       <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_tx_go) begin
                r_resp_data <= r_resp_data >> 8;
                r_resp_left <= r_resp_left - 1'b1;
            end
            case (r_state)
                S_IDLE, S_ADDR, S_WDATA: begin
                    if (r_rx_ferr || (r_rx_vld && r_state == S_IDLE &&
                                      r_rx_byte != 8'h80 && r_rx_byte != 8'h00)) begin
                        r_err       <= 1'b1;
                        r_resp_data <= ADW'(8'h15);
                        r_resp_left <= BCW'(1);
                        r_state     <= S_RESP;
                    end else if (r_rx_vld) begin
                        case (r_state)
                            S_IDLE: begin
                                r_is_wr <= r_rx_byte[7];
                                r_state <= S_ADDR;
                            end
                            S_ADDR: begin
                                r_addr <= r_rx_byte[AAW-1:0];
                                r_bcnt <= '0;
                                if (r_is_wr) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_rd    <= 1'b1;
                                    r_be    <= '1;
                                    r_state <= S_BUS_RD;
                                end
                            end
                            default: begin
                                for (int k = 0; k < ABW; k++) begin
                                    if (r_bcnt == BCW'(k)) r_wdata[8*k +: 8] <= r_rx_byte;
                                end
                                if (r_bcnt == LAST_B) begin
                                    r_wr    <= 1'b1;
                                    r_be    <= '1;
                                    r_state <= S_BUS_WR;
                                end else begin
                                    r_bcnt <= r_bcnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_BUS_WR: begin
                    if (!avm_waitrequest) begin
                        r_wr        <= 1'b0;
                        r_be        <= '0;
                        r_resp_data <= ADW'(8'h06);
                        r_resp_left <= BCW'(1);
                        r_state     <= S_RESP;
                    end
                end
                S_BUS_RD: begin
                    if (!avm_waitrequest) begin
                        r_rd        <= 1'b0;
                        r_be        <= '0;
                        r_resp_data <= avm_readdata;
                        r_resp_left <= BCW'(ABW);
                        r_state     <= S_RESP;
                    end
                end
                default: begin
                    if (r_resp_left == '0 && w_tx_done) r_state <= S_IDLE;
                end
            endcase
            // Bytes landing while the bus or the reply is in flight are dropped.
            if ((r_rx_vld || r_rx_ferr) &&
                (r_state == S_BUS_WR || r_state == S_BUS_RD || r_state == S_RESP))
                r_err <= 1'b1;
        end
    end

    assign uart_txd       = r_txd;
    assign avm_address    = r_addr;
    assign avm_read       = r_rd;
    assign avm_write      = r_wr;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = r_be;
    assign status_err     = r_err;

endmodule
